// File: rtl/qpu_meas_pkg.sv
// Shared definitions for the measurement-track retire logic:
// qubit count and the retire sequencer state encoding.
package qpu_meas_pkg;

    localparam int QUBIT_NUM = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WBCK    = 2'd2,
        ST_ERR     = 2'd3
    } meas_st_e;

endpackage

// File: rtl/qpu_meas_res_acc.sv
// Single-qubit result slot: holds the last returned measurement bit until
// the entry that owns the qubit retires. Instantiated once per qubit.
module qpu_meas_res_acc (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic val,
    input  logic clr,
    output logic res_vld,
    output logic res,
    output logic dup
);

    // A fresh result beats a same-cycle retire clear, so a result for the next
    // entry on this qubit is never lost and is not treated as a duplicate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_vld <= 1'b0;
            res     <= 1'b0;
        end else if (set) begin
            res_vld <= 1'b1;
            res     <= val;
        end else if (clr) begin
            res_vld <= 1'b0;
        end
    end

    assign dup = set & res_vld & ~clr;

endmodule

// File: rtl/qpu_exu_meas_retire.sv
// Retire sequencer for the EXU measurement FIFO head: gathers per-qubit
// results, issues one qubit-result writeback, then pops the head.
module qpu_exu_meas_retire #(
    parameter int QUBIT_NUM = qpu_meas_pkg::QUBIT_NUM,
    parameter int TMO_W     = 16,
    parameter int TMO_CYC   = 40000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mf_head_vld,
    input  logic [QUBIT_NUM-1:0] mf_head_ql,
    input  logic [QUBIT_NUM-1:0] mcu_res_vld,
    input  logic [QUBIT_NUM-1:0] mcu_res_val,
    output logic                 ret_qf_ena,
    output logic                 qwb_vld,
    input  logic                 qwb_rdy,
    output logic [QUBIT_NUM-1:0] qwb_mask,
    output logic [QUBIT_NUM-1:0] qwb_dat,
    input  logic                 err_clr,
    output logic                 err_tmo,
    output logic                 err_dup,
    output logic                 busy
);
    import qpu_meas_pkg::*;

    meas_st_e             st, st_nxt;
    logic [QUBIT_NUM-1:0] pend_r;
    logic [QUBIT_NUM-1:0] res_vld_r;
    logic [QUBIT_NUM-1:0] res_r;
    logic [QUBIT_NUM-1:0] dup_vec;
    logic [QUBIT_NUM-1:0] wb_dat_r;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 done;

    for (genvar j = 0; j < QUBIT_NUM; j++) begin : g_acc
        qpu_meas_res_acc u_acc (
            .clk     (clk),
            .rst     (rst),
            .set     (mcu_res_vld[j]),
            .val     (mcu_res_val[j]),
            .clr     (ret_qf_ena & pend_r[j]),
            .res_vld (res_vld_r[j]),
            .res     (res_r[j]),
            .dup     (dup_vec[j])
        );
    end

    assign done = ((res_vld_r & pend_r) == pend_r);

    always_comb begin
        st_nxt     = st;
        ret_qf_ena = 1'b0;
        qwb_vld    = 1'b0;
        err_tmo    = 1'b0;
        case (st)
            ST_IDLE: begin
                if (mf_head_vld) st_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (done)                                   st_nxt = ST_WBCK;
                else if (tmo_cnt == TMO_W'(TMO_CYC - 1))    st_nxt = ST_ERR;
            end
            ST_WBCK: begin
                qwb_vld = 1'b1;
                if (qwb_rdy) begin
                    ret_qf_ena = 1'b1;
                    st_nxt     = ST_IDLE;
                end
            end
            ST_ERR: begin
                err_tmo = 1'b1;
                if (err_clr) begin
                    ret_qf_ena = 1'b1;
                    st_nxt     = ST_IDLE;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    // Write data is frozen on entry to WBCK so a late duplicate cannot
    // disturb a request that is already presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            pend_r   <= '0;
            tmo_cnt  <= '0;
            wb_dat_r <= '0;
            err_dup  <= 1'b0;
        end else begin
            st      <= st_nxt;
            err_dup <= (err_dup & ~((st == ST_ERR) & err_clr)) | (|dup_vec);
            case (st)
                ST_IDLE: begin
                    if (mf_head_vld) begin
                        pend_r  <= mf_head_ql;
                        tmo_cnt <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (done) wb_dat_r <= res_r & pend_r;
                    else      tmo_cnt  <= tmo_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign qwb_mask = qwb_vld ? pend_r   : '0;
    assign qwb_dat  = qwb_vld ? wb_dat_r : '0;
    assign busy     = (st != ST_IDLE);

endmodule

// File: tb/tb_qpu_exu_meas_retire.sv
// Directed bench for the measurement retire sequencer: a rule-level model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_qpu_exu_meas_retire;

    localparam int QN  = 12;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          mf_head_vld = 1'b0;
    logic [QN-1:0] mf_head_ql  = '0;
    logic [QN-1:0] mcu_res_vld = '0;
    logic [QN-1:0] mcu_res_val = '0;
    logic          qwb_rdy     = 1'b0;
    logic          err_clr     = 1'b0;
    logic          ret_qf_ena, qwb_vld, err_tmo, err_dup, busy;
    logic [QN-1:0] qwb_mask, qwb_dat;

    int total = 0;
    int bad   = 0;
    logic [QN-1:0] fifo[$];

    qpu_exu_meas_retire #(.QUBIT_NUM(QN), .TMO_W(16), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .mf_head_vld(mf_head_vld), .mf_head_ql(mf_head_ql),
        .mcu_res_vld(mcu_res_vld), .mcu_res_val(mcu_res_val), .ret_qf_ena(ret_qf_ena),
        .qwb_vld(qwb_vld), .qwb_rdy(qwb_rdy), .qwb_mask(qwb_mask), .qwb_dat(qwb_dat),
        .err_clr(err_clr), .err_tmo(err_tmo), .err_dup(err_dup), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- rule-level model ----------------
    // phase: 0 waiting for head, 1 gathering, 2 writing back, 3 timed out
    int            m_ph   = 0;
    int            m_wait = 0;
    logic [QN-1:0] m_list = '0, m_got = '0, m_bit = '0, m_wb = '0;
    logic          m_dup  = 1'b0;
    logic [QN-1:0] n_got, n_bit;
    logic          n_dup, n_all, n_ret;

    function automatic logic m_ret();
        return (m_ph == 2 && qwb_rdy) || (m_ph == 3 && err_clr);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_wait <= 0; m_list <= '0; m_got <= '0;
            m_bit <= '0; m_wb <= '0; m_dup <= 1'b0;
        end else begin
            n_ret = m_ret();
            n_got = m_got; n_bit = m_bit; n_dup = 1'b0; n_all = 1'b1;
            for (int q = 0; q < QN; q++) begin
                if (m_list[q] && !m_got[q]) n_all = 1'b0;
                if (mcu_res_vld[q]) begin
                    if (m_got[q] && !(n_ret && m_list[q])) n_dup = 1'b1;
                    n_got[q] = 1'b1;
                    n_bit[q] = mcu_res_val[q];
                end else if (n_ret && m_list[q]) begin
                    n_got[q] = 1'b0;
                end
            end
            m_got <= n_got;
            m_bit <= n_bit;
            m_dup <= (m_dup && !(m_ph == 3 && err_clr)) || n_dup;
            case (m_ph)
                0: if (mf_head_vld) begin m_list <= mf_head_ql; m_wait <= 0; m_ph <= 1; end
                1: if (n_all) begin m_wb <= m_bit & m_list; m_ph <= 2; end
                   else if (m_wait == TMO - 1) m_ph <= 3;
                   else m_wait <= m_wait + 1;
                2: if (qwb_rdy) m_ph <= 0;
                default: if (err_clr) m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cyc_qwb_vld",  32'(qwb_vld),    32'(m_ph == 2));
        chk("cyc_qwb_mask", 32'(qwb_mask),   32'((m_ph == 2) ? m_list : '0));
        chk("cyc_qwb_dat",  32'(qwb_dat),    32'((m_ph == 2) ? m_wb : '0));
        chk("cyc_ret",      32'(ret_qf_ena), 32'(m_ret()));
        chk("cyc_err_tmo",  32'(err_tmo),    32'(m_ph == 3));
        chk("cyc_err_dup",  32'(err_dup),    32'(m_dup));
        chk("cyc_busy",     32'(busy),       32'(m_ph != 0));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        logic pop;
        @(negedge clk);
        pop = ret_qf_ena;
        @(posedge clk);
        #1;
        if (pop && fifo.size() > 0) void'(fifo.pop_front());
        mf_head_vld = (fifo.size() > 0);
        mf_head_ql  = (fifo.size() > 0) ? fifo[0] : '0;
        mcu_res_vld = '0;
        mcu_res_val = '0;
        err_clr     = 1'b0;
    endtask

    task automatic push(input logic [QN-1:0] ql);
        fifo.push_back(ql);
        mf_head_vld = 1'b1;
        mf_head_ql  = fifo[0];
    endtask

    task automatic res(input logic [QN-1:0] v, input logic [QN-1:0] d);
        mcu_res_vld = v;
        mcu_res_val = d;
    endtask

    task automatic wait_wb(input int n);
        int k = 0;
        while (!qwb_vld && k < n) begin step(); k++; end
        chk("wb_reached", 32'(qwb_vld), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step(); step();
        chk("rst_vld",  32'(qwb_vld),  32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_ret",  32'(ret_qf_ena), 32'd0);
        chk("rst_dup",  32'(err_dup),  32'd0);
        rst = 1'b0;
        step();

        // 1: q0=1 at edge t, q2=0 at t+3, writeback visible after t+4
        qwb_rdy = 1'b1;
        push(12'h005);
        step();                      // now gathering
        res(12'h001, 12'h001);
        step(); step(); step();
        res(12'h004, 12'h000);
        step();
        chk("t1_not_yet", 32'(qwb_vld), 32'd0);
        step();
        chk("t1_vld",  32'(qwb_vld),  32'd1);
        chk("t1_mask", 32'(qwb_mask), 32'h005);
        chk("t1_dat",  32'(qwb_dat),  32'h001);
        chk("t1_ret",  32'(ret_qf_ena), 32'd1);
        step();
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: backpressure for 5 cycles, q0=0 q2=1
        qwb_rdy = 1'b0;
        push(12'h005);
        step();
        res(12'h001, 12'h000);
        step(); step(); step();
        res(12'h004, 12'h004);
        step(); step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_vld",  32'(qwb_vld),  32'd1);
            chk("t2_mask", 32'(qwb_mask), 32'h005);
            chk("t2_dat",  32'(qwb_dat),  32'h004);
            chk("t2_noret", 32'(ret_qf_ena), 32'd0);
            step();
        end
        qwb_rdy = 1'b1;
        #1;
        chk("t2_ret", 32'(ret_qf_ena), 32'd1);
        step();
        chk("t2_idle", 32'(busy), 32'd0);

        // 3: two entries, q1 result arrives before q0
        push(12'h001);
        push(12'h002);
        res(12'h002, 12'h002);
        step(); step();
        res(12'h001, 12'h000);
        step();
        wait_wb(5);
        chk("t3_mask0", 32'(qwb_mask), 32'h001);
        chk("t3_dat0",  32'(qwb_dat),  32'h000);
        step();
        wait_wb(5);
        chk("t3_mask1", 32'(qwb_mask), 32'h002);
        chk("t3_dat1",  32'(qwb_dat),  32'h002);
        res(12'h002, 12'h000);       // lands in the retire cycle of its own qubit
        #1;
        chk("t3_ret", 32'(ret_qf_ena), 32'd1);
        step();
        step();
        chk("t3_nodup", 32'(err_dup), 32'd0);

        // 5: duplicate q3 result, second value wins
        res(12'h008, 12'h008);
        step();
        res(12'h008, 12'h000);
        step();
        chk("t5_dup", 32'(err_dup), 32'd1);
        push(12'h008);
        wait_wb(6);
        chk("t5_mask", 32'(qwb_mask), 32'h008);
        chk("t5_dat",  32'(qwb_dat),  32'h000);
        step();

        // 4: timeout after TMO gathering cycles, then clear
        push(12'h008);
        step();
        for (int i = 0; i < TMO - 1; i++) step();
        chk("t4_pre_tmo", 32'(err_tmo), 32'd0);
        step();
        chk("t4_tmo", 32'(err_tmo), 32'd1);
        chk("t4_nowb", 32'(qwb_vld), 32'd0);
        err_clr = 1'b1;
        #1;
        chk("t4_ret", 32'(ret_qf_ena), 32'd1);
        step();
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_dup_clr", 32'(err_dup), 32'd0);
        err_clr = 1'b1;              // ignored outside the error state
        #1;
        chk("t4_clr_ignored", 32'(ret_qf_ena), 32'd0);
        step();

        // 6: reset while a writeback is presented
        qwb_rdy = 1'b0;
        push(12'h002);
        step(); step();
        chk("t6_vld", 32'(qwb_vld), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_vld",  32'(qwb_vld),    32'd0);
        chk("t6_rst_busy", 32'(busy),       32'd0);
        chk("t6_rst_ret",  32'(ret_qf_ena), 32'd0);
        step(); step();
        rst = 1'b0;
        qwb_rdy = 1'b1;
        res(12'h002, 12'h002);
        wait_wb(6);
        chk("t6_mask", 32'(qwb_mask), 32'h002);
        chk("t6_dat",  32'(qwb_dat),  32'h002);
        step();
        chk("t6_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
